// File: rtl/q_sched_pkg.sv
// Shared constants and types for the q-hypothesis search scheduler.
// Buffer sizes, the FSM state encoding, the hypothesis index type and the metric ceiling.
package q_sched_pkg;
  localparam int H_BEATS = 16;
  localparam int Y_BEATS = 8;
  localparam int DQ_W    = 32;
  localparam logic [DQ_W-1:0] DQ_MAX = {1'b0, {(DQ_W-1){1'b1}}};

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_FEED    = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_UPDATE  = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT,
    S_START   = ST_START,
    S_FEED    = ST_FEED,
    S_WAIT    = ST_WAIT,
    S_UPDATE  = ST_UPDATE,
    S_DONE    = ST_DONE
  } state_t;

  typedef logic [3:0] q_idx_t;
endpackage

// File: rtl/q_frame_buffer.sv
// Frame storage for one 4x4 H matrix and one Y block: write counters with full
// flags while collecting, indexed combinational read for the replay.
module q_frame_buffer
  import q_sched_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         wr_en,
  input  logic         h_valid,
  input  logic [N-1:0] h_r,
  input  logic [N-1:0] h_i,
  output logic         h_ready,
  input  logic         y_valid,
  input  logic [N-1:0] y_r,
  input  logic [N-1:0] y_i,
  output logic         y_ready,
  output logic         load_done,
  input  logic [3:0]   rd_idx,
  output logic [N-1:0] rd_h_r,
  output logic [N-1:0] rd_h_i,
  output logic [N-1:0] rd_y_r,
  output logic [N-1:0] rd_y_i
);
  logic [N-1:0] h_mem_r [H_BEATS];
  logic [N-1:0] h_mem_i [H_BEATS];
  logic [N-1:0] y_mem_r [Y_BEATS];
  logic [N-1:0] y_mem_i [Y_BEATS];
  logic [4:0]   h_cnt;
  logic [3:0]   y_cnt;
  logic         h_full, y_full, h_acc, y_acc;

  assign h_full  = (h_cnt == 5'(H_BEATS));
  assign y_full  = (y_cnt == 4'(Y_BEATS));
  assign h_ready = wr_en && !h_full;
  assign y_ready = wr_en && !y_full;
  assign h_acc   = h_valid && h_ready;
  assign y_acc   = y_valid && y_ready;

  // Look one beat ahead so the start pulse follows the final accept directly.
  assign load_done = (h_full || (h_acc && h_cnt == 5'(H_BEATS-1))) &&
                     (y_full || (y_acc && y_cnt == 4'(Y_BEATS-1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      y_cnt <= '0;
    end else if (clr) begin
      h_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (h_acc) h_cnt <= h_cnt + 5'd1;
      if (y_acc) y_cnt <= y_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (h_acc) begin
      h_mem_r[h_cnt[3:0]] <= h_r;
      h_mem_i[h_cnt[3:0]] <= h_i;
    end
    if (y_acc) begin
      y_mem_r[y_cnt[2:0]] <= y_r;
      y_mem_i[y_cnt[2:0]] <= y_i;
    end
  end

  assign rd_h_r = h_mem_r[rd_idx];
  assign rd_h_i = h_mem_i[rd_idx];
  assign rd_y_r = y_mem_r[rd_idx[2:0]];
  assign rd_y_i = y_mem_i[rd_idx[2:0]];
endmodule

// File: rtl/q_search_scheduler.sv
// Frame controller for x_calculate: buffers H/Y, replays them per hypothesis and keeps the min-dq winner.
// Optional Q_SEARCH_TIMEOUT_EN adds a per-hypothesis WAIT timeout and the sticky timeout_err output.
module q_search_scheduler
  import q_sched_pkg::*;
#(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int NUM_Q   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         frame_start,
  input  logic         h_valid,
  input  logic [N-1:0] h_r,
  input  logic [N-1:0] h_i,
  output logic         h_ready,
  input  logic         y_valid,
  input  logic [N-1:0] y_r,
  input  logic [N-1:0] y_i,
  output logic         y_ready,
  output logic         xc_start_new_q,
  output logic [3:0]   xc_q_index,
  output logic         xc_h_valid,
  output logic [N-1:0] xc_h_r,
  output logic [N-1:0] xc_h_i,
  output logic         xc_y_valid,
  output logic [N-1:0] xc_y_r,
  output logic [N-1:0] xc_y_i,
  input  logic         xc_q_done,
  input  logic [N-1:0] xc_dq,
  input  logic [N-1:0] xc_xI1,
  input  logic [N-1:0] xc_xQ1,
  input  logic [N-1:0] xc_xI2,
  input  logic [N-1:0] xc_xQ2,
  output logic         best_valid,
  output logic [3:0]   best_q,
  output logic [N-1:0] best_dq,
  output logic [N-1:0] best_xI1,
  output logic [N-1:0] best_xQ1,
  output logic [N-1:0] best_xI2,
  output logic [N-1:0] best_xQ2,
  output logic         busy
`ifdef Q_SEARCH_TIMEOUT_EN
  , output logic       timeout_err
`endif
);
  if (NUM_Q < 1 || NUM_Q > 16 || Q < 0 || Q >= N || TIMEOUT < 1) begin : g_cfg_err
    $error("q_search_scheduler: unsupported parameter set");
  end

  localparam logic [N-1:0] DQ_INIT = {1'b0, {(N-1){1'b1}}};

  state_t              state;
  q_idx_t              q;
  logic [3:0]          k;
  logic [3:0]          rd_idx;
  logic                load_done;
  logic [N-1:0]        rd_h_r, rd_h_i, rd_y_r, rd_y_i;
  logic                cand_ok;
  logic [N-1:0]        cand_dq;
  logic [3:0][N-1:0]   cand_x;
  logic                min_ok;
  q_idx_t              min_q;
  logic [N-1:0]        min_dq;
  logic [3:0][N-1:0]   min_x;
  logic [3:0][N-1:0]   best_x;
  logic                win;
  q_idx_t              nxt_q;
  logic [N-1:0]        nxt_dq;
  logic [3:0][N-1:0]   nxt_x;
`ifdef Q_SEARCH_TIMEOUT_EN
  localparam int WT = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WT-1:0]       wait_cnt;
`endif

  assign rd_idx = (state == S_FEED) ? k + 4'd1 : 4'd0;

  q_frame_buffer #(.N(N)) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (state == S_IDLE && frame_start),
    .wr_en     (state == S_COLLECT),
    .h_valid   (h_valid),
    .h_r       (h_r),
    .h_i       (h_i),
    .h_ready   (h_ready),
    .y_valid   (y_valid),
    .y_r       (y_r),
    .y_i       (y_i),
    .y_ready   (y_ready),
    .load_done (load_done),
    .rd_idx    (rd_idx),
    .rd_h_r    (rd_h_r),
    .rd_h_i    (rd_h_i),
    .rd_y_r    (rd_y_r),
    .rd_y_i    (rd_y_i)
  );

  // A discarded (timed-out) candidate never wins; strict less-than keeps the lower q on ties.
  always_comb begin
    win    = cand_ok && (q == '0 || !min_ok || $signed(cand_dq) < $signed(min_dq));
    nxt_q  = win ? q       : min_q;
    nxt_dq = win ? cand_dq : min_dq;
    nxt_x  = win ? cand_x  : min_x;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      q              <= '0;
      k              <= '0;
      xc_start_new_q <= 1'b0;
      xc_h_valid     <= 1'b0;
      xc_h_r         <= '0;
      xc_h_i         <= '0;
      xc_y_valid     <= 1'b0;
      xc_y_r         <= '0;
      xc_y_i         <= '0;
      cand_ok        <= 1'b0;
      cand_dq        <= '0;
      cand_x         <= '0;
      min_ok         <= 1'b0;
      min_q          <= '0;
      min_dq         <= '0;
      min_x          <= '0;
      best_valid     <= 1'b0;
      best_q         <= '0;
      best_dq        <= '0;
      best_x         <= '0;
`ifdef Q_SEARCH_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      xc_start_new_q <= 1'b0;
      best_valid     <= 1'b0;
      case (state)
        S_IDLE: if (frame_start) begin
          state  <= S_COLLECT;
          q      <= '0;
          min_ok <= 1'b0;
          min_q  <= '0;
          min_dq <= DQ_INIT;
          min_x  <= '0;
`ifdef Q_SEARCH_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
        end
        S_COLLECT: if (load_done) begin
          state          <= S_START;
          xc_start_new_q <= 1'b1;
        end
        S_START: begin
          state      <= S_FEED;
          k          <= '0;
          xc_h_valid <= 1'b1;
          xc_h_r     <= rd_h_r;
          xc_h_i     <= rd_h_i;
          xc_y_valid <= 1'b1;
          xc_y_r     <= rd_y_r;
          xc_y_i     <= rd_y_i;
        end
        // Outputs are registered, so each FEED cycle loads the following beat.
        S_FEED: if (k == 4'(H_BEATS-1)) begin
          state      <= S_WAIT;
          xc_h_valid <= 1'b0;
          xc_h_r     <= '0;
          xc_h_i     <= '0;
          xc_y_valid <= 1'b0;
          xc_y_r     <= '0;
          xc_y_i     <= '0;
`ifdef Q_SEARCH_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end else begin
          k          <= k + 4'd1;
          xc_h_valid <= 1'b1;
          xc_h_r     <= rd_h_r;
          xc_h_i     <= rd_h_i;
          xc_y_valid <= (k < 4'(Y_BEATS-1));
          xc_y_r     <= (k < 4'(Y_BEATS-1)) ? rd_y_r : '0;
          xc_y_i     <= (k < 4'(Y_BEATS-1)) ? rd_y_i : '0;
        end
        S_WAIT: if (xc_q_done) begin
          state   <= S_UPDATE;
          cand_ok <= 1'b1;
          cand_dq <= xc_dq;
          cand_x  <= {xc_xQ2, xc_xI2, xc_xQ1, xc_xI1};
        end
`ifdef Q_SEARCH_TIMEOUT_EN
        else if (wait_cnt == WT'(TIMEOUT-1)) begin
          state       <= S_UPDATE;
          cand_ok     <= 1'b0;
          timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
`endif
        S_UPDATE: begin
          min_ok <= min_ok | win;
          min_q  <= nxt_q;
          min_dq <= nxt_dq;
          min_x  <= nxt_x;
          if (q == q_idx_t'(NUM_Q-1)) begin
            state      <= S_DONE;
            best_valid <= 1'b1;
            best_q     <= nxt_q;
            best_dq    <= nxt_dq;
            best_x     <= nxt_x;
          end else begin
            state          <= S_START;
            q              <= q + 4'd1;
            xc_start_new_q <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign xc_q_index = q;
  assign best_xI1   = best_x[0];
  assign best_xQ1   = best_x[1];
  assign best_xI2   = best_x[2];
  assign best_xQ2   = best_x[3];
  assign busy       = (state != S_IDLE);
endmodule

// File: tb/tb_q_search_scheduler.sv
// Bench for q_search_scheduler: x_calculate stub with bit-exact replay checking and a
// min-dq reference model; timeout scenarios run when Q_SEARCH_TIMEOUT_EN is defined.
module tb_q_search_scheduler;
  localparam int N     = 32;
  localparam int NUM_Q = 16;
`ifdef Q_SEARCH_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         frame_start, h_valid, y_valid, h_ready, y_ready;
  logic [N-1:0] h_r, h_i, y_r, y_i;
  logic         xc_start_new_q, xc_h_valid, xc_y_valid, xc_q_done;
  logic [3:0]   xc_q_index, best_q;
  logic [N-1:0] xc_h_r, xc_h_i, xc_y_r, xc_y_i;
  logic [N-1:0] xc_dq, xc_xI1, xc_xQ1, xc_xI2, xc_xQ2;
  logic         best_valid, busy;
  logic [N-1:0] best_dq, best_xI1, best_xQ1, best_xI2, best_xQ2;
`ifdef Q_SEARCH_TIMEOUT_EN
  logic         timeout_err;
`endif

  q_search_scheduler #(.N(N), .Q(16), .NUM_Q(NUM_Q), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start),
    .h_valid(h_valid), .h_r(h_r), .h_i(h_i), .h_ready(h_ready),
    .y_valid(y_valid), .y_r(y_r), .y_i(y_i), .y_ready(y_ready),
    .xc_start_new_q(xc_start_new_q), .xc_q_index(xc_q_index),
    .xc_h_valid(xc_h_valid), .xc_h_r(xc_h_r), .xc_h_i(xc_h_i),
    .xc_y_valid(xc_y_valid), .xc_y_r(xc_y_r), .xc_y_i(xc_y_i),
    .xc_q_done(xc_q_done), .xc_dq(xc_dq),
    .xc_xI1(xc_xI1), .xc_xQ1(xc_xQ1), .xc_xI2(xc_xI2), .xc_xQ2(xc_xQ2),
    .best_valid(best_valid), .best_q(best_q), .best_dq(best_dq),
    .best_xI1(best_xI1), .best_xQ1(best_xQ1), .best_xI2(best_xI2), .best_xQ2(best_xQ2),
    .busy(busy)
`ifdef Q_SEARCH_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [N-1:0] h_mem_r [16];
  logic [N-1:0] h_mem_i [16];
  logic [N-1:0] y_mem_r [8];
  logic [N-1:0] y_mem_i [8];
  logic [N-1:0] dq_tab [NUM_Q];
  int           dly_tab [NUM_Q];
  bit           never_done [NUM_Q];
  int           starts, replay_bad, bv_cnt;

  function automatic logic [N-1:0] xv(input int qq, input int j);
    return N'(j * 4096 + qq * 16 + 7);
  endfunction

  // x_calculate stand-in: checks the replay and answers after dly_tab[q] WAIT cycles.
  initial begin
    int phase, beat, wleft, cur_q;
    phase = 0; beat = 0; wleft = 0; cur_q = 0;
    starts = 0; replay_bad = 0; bv_cnt = 0;
    xc_q_done = 1'b0; xc_dq = '0;
    xc_xI1 = '0; xc_xQ1 = '0; xc_xI2 = '0; xc_xQ2 = '0;
    forever begin
      @(negedge clk);
      xc_q_done = 1'b0;
      if (!rstn) begin
        phase = 0;
      end else begin
        if (best_valid) bv_cnt++;
        case (phase)
          0: begin
            if (xc_h_valid || xc_y_valid) replay_bad++;
            if (xc_start_new_q) begin
              if (int'(xc_q_index) != starts) replay_bad++;
              starts++;
              cur_q = int'(xc_q_index);
              beat  = 0;
              phase = 1;
            end
          end
          1: begin
            if (xc_start_new_q || int'(xc_q_index) != cur_q) replay_bad++;
            if (!xc_h_valid || xc_h_r !== h_mem_r[beat] || xc_h_i !== h_mem_i[beat]) replay_bad++;
            if (beat < 8) begin
              if (!xc_y_valid || xc_y_r !== y_mem_r[beat] || xc_y_i !== y_mem_i[beat]) replay_bad++;
            end else if (xc_y_valid) replay_bad++;
            beat++;
            if (beat == 16) begin
              phase = 2;
              wleft = dly_tab[cur_q];
            end
          end
          default: begin
            if (xc_h_valid || xc_start_new_q || int'(xc_q_index) != cur_q) replay_bad++;
            wleft--;
            if (wleft <= 0) begin
              phase = 0;
              if (!never_done[cur_q]) begin
                xc_q_done = 1'b1;
                xc_dq  = dq_tab[cur_q];
                xc_xI1 = xv(cur_q, 0);
                xc_xQ1 = xv(cur_q, 1);
                xc_xI2 = xv(cur_q, 2);
                xc_xQ2 = xv(cur_q, 3);
              end
            end
          end
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: smallest signed dq among answering hypotheses, earliest q on ties.
  task automatic model(output int eq, output logic [N-1:0] edq, output bit any);
    logic signed [N-1:0] m;
    any = 0; m = '0; eq = 0;
    edq = {1'b0, {(N-1){1'b1}}};
    for (int i = 0; i < NUM_Q; i++)
      if (!never_done[i] && (!any || $signed(dq_tab[i]) < m)) begin
        m = dq_tab[i];
        any = 1;
      end
    if (any) begin
      edq = m;
      for (int i = NUM_Q - 1; i >= 0; i--)
        if (!never_done[i] && dq_tab[i] == m) eq = i;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    starts = 0;
    replay_bad = 0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("ready_after_start", {62'd0, h_ready, y_ready}, 64'd3);
`ifdef Q_SEARCH_TIMEOUT_EN
    chk("timeout_err_cleared", {63'd0, timeout_err}, 64'd0);
`endif
  endtask

  // Offers up to h_total H beats; Y is held back until all H offers are made when y_hold.
  task automatic collect(input int gap, input int h_total, input bit y_hold, output int ha);
    int ya, ho, cyc;
    ha = 0; ya = 0; ho = 0; cyc = 0;
    while ((ha < 16 || ya < 8) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      h_valid = (ho < h_total) && ($urandom_range(99) >= gap);
      if (h_valid) begin
        h_r = $urandom; h_i = $urandom;
        ho++;
        if (ha >= 16) chk("h_ready_when_full", {63'd0, h_ready}, 64'd0);
        if (h_ready) begin
          if (ha < 16) begin h_mem_r[ha] = h_r; h_mem_i[ha] = h_i; end
          ha++;
        end
      end
      y_valid = (ya < 8) && (!y_hold || ho >= h_total) && ($urandom_range(99) >= gap);
      if (y_valid) begin
        y_r = $urandom; y_i = $urandom;
        if (y_ready) begin
          if (ya < 8) begin y_mem_r[ya] = y_r; y_mem_i[ya] = y_i; end
          ya++;
        end
      end
    end
    @(negedge clk);
    h_valid = 1'b0;
    y_valid = 1'b0;
    chk("start_after_last_beat", {63'd0, xc_start_new_q}, 64'd1);
    chk("y_accepted", 64'(ya), 64'd8);
  endtask

  task automatic finish_frame(input string pfx);
    int eq, cyc, bv0;
    logic [N-1:0] edq;
    bit any;
    model(eq, edq, any);
    bv0 = bv_cnt;
    cyc = 0;
    while (!best_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({pfx, "_best_valid"}, {63'd0, best_valid}, 64'd1);
    chk({pfx, "_best_q"}, 64'(best_q), 64'(eq));
    chk({pfx, "_best_dq"}, 64'(best_dq), 64'(edq));
    chk({pfx, "_best_x"}, {best_xQ2, best_xI1}, any ? {xv(eq, 3), xv(eq, 0)} : 64'd0);
    chk({pfx, "_best_x2"}, {best_xQ1, best_xI2}, any ? {xv(eq, 1), xv(eq, 2)} : 64'd0);
    chk({pfx, "_starts"}, 64'(starts), 64'(NUM_Q));
    chk({pfx, "_replay"}, 64'(replay_bad), 64'd0);
    chk({pfx, "_busy_done"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk({pfx, "_pulse_once"}, {62'd0, best_valid, busy}, 64'd0);
    chk({pfx, "_bv_count"}, 64'(bv_cnt - bv0), 64'd1);
    repeat (3) @(negedge clk);
    chk({pfx, "_best_hold"}, {32'(best_q), best_dq}, {32'(eq), edq});
  endtask

  function automatic logic outputs_any();
    return |{h_ready, y_ready, xc_start_new_q, xc_q_index, xc_h_valid, xc_h_r, xc_h_i,
             xc_y_valid, xc_y_r, xc_y_i, best_valid, best_q, best_dq,
             best_xI1, best_xQ1, best_xI2, best_xQ2, busy};
  endfunction

  initial begin
    int ha, cyc, bv0;
    frame_start = 1'b0; h_valid = 1'b0; y_valid = 1'b0;
    h_r = '0; h_i = '0; y_r = '0; y_i = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      dq_tab[i] = '0; dly_tab[i] = 5; never_done[i] = 0;
    end

    // Reset with random inputs
    rstn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      frame_start = 1'($urandom); h_valid = 1'($urandom); y_valid = 1'($urandom);
      h_r = $urandom; y_r = $urandom;
    end
    chk("reset_outputs", {63'd0, outputs_any()}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    frame_start = 1'b0; h_valid = 1'b0; y_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal: V-shaped metric with its minimum at q=9
    for (int i = 0; i < NUM_Q; i++) begin
      dq_tab[i] = N'(100 + 3 * ((i > 9) ? i - 9 : 9 - i));
      dly_tab[i] = 5;
    end
    start_frame();
    collect(0, 16, 0, ha);
    finish_frame("nominal");

    // Ties keep the lower q
    for (int i = 0; i < NUM_Q; i++) dq_tab[i] = (i == 3 || i == 7) ? N'(50) : N'(80);
    start_frame();
    collect(20, 16, 0, ha);
    finish_frame("ties");

    // Back-pressure: 20 H beats offered with gaps, Y held back
    for (int i = 0; i < NUM_Q; i++) begin
      dq_tab[i] = N'($urandom_range(1000));
      dly_tab[i] = $urandom_range(1, 8);
    end
    start_frame();
    collect(40, 20, 1, ha);
    chk("h_accepted", 64'(ha), 64'd16);
    finish_frame("bp");

    // Random signed metrics, including negative values and a forced duplicate
    for (int i = 0; i < NUM_Q; i++) begin
      dq_tab[i] = N'($signed($urandom_range(2000)) - 1000);
      dly_tab[i] = $urandom_range(1, 8);
    end
    dq_tab[12] = dq_tab[2];
    start_frame();
    collect(30, 16, 0, ha);
    finish_frame("rand");

    // Reset during FEED of q=5 aborts without a result
    start_frame();
    collect(10, 16, 0, ha);
    cyc = 0;
    while (!(xc_start_new_q && xc_q_index == 4'd5) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_q5", {63'd0, xc_start_new_q}, 64'd1);
    repeat (3) @(negedge clk);
    bv0 = bv_cnt;
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {63'd0, outputs_any()}, 64'd0);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_best", 64'(bv_cnt - bv0), 64'd0);
    chk("abort_idle", {63'd0, busy}, 64'd0);
    for (int i = 0; i < NUM_Q; i++) dq_tab[i] = N'($urandom_range(500));
    start_frame();
    collect(0, 16, 0, ha);
    finish_frame("after_abort");

`ifdef Q_SEARCH_TIMEOUT_EN
    // q=4 would win but never answers
    for (int i = 0; i < NUM_Q; i++) begin
      dq_tab[i] = N'($urandom_range(100, 900));
      dly_tab[i] = $urandom_range(1, 8);
    end
    dq_tab[4] = N'(-1000);
    never_done[4] = 1;
    start_frame();
    collect(0, 16, 0, ha);
    finish_frame("tmo_q4");
    chk("tmo_err_set", {63'd0, timeout_err}, 64'd1);
    chk("tmo_not_q4", {63'd0, best_q == 4'd4}, 64'd0);

    // Every hypothesis times out
    for (int i = 0; i < NUM_Q; i++) never_done[i] = 1;
    start_frame();
    collect(0, 16, 0, ha);
    finish_frame("tmo_all");
    chk("tmo_all_err", {63'd0, timeout_err}, 64'd1);
    for (int i = 0; i < NUM_Q; i++) never_done[i] = 0;
    start_frame();
    collect(0, 16, 0, ha);
    finish_frame("tmo_clear");
    chk("tmo_clear_err", {63'd0, timeout_err}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
